noc_output_arbiter: RTL and testbench
=====================================

Name: noc_output_arbiter

Overview:
- Round-robin, packet-locking arbiter for one router output port in the NoC switch stage.
- Arbitrates among NUM_REQ input requesters (input ports or VCs) and holds the grant for the whole packet, wormhole style, until the tail flit is transferred.
- Drives a registered one-hot grant vector plus its binary index. The index is produced by the codebase's one-hot-to-binary encoder for crossbar mux selection.

Parameters:
- NUM_REQ, 8, number of requesters; must be ≥ 2.
- ID_W, 3, width of the grant index; must satisfy 2^ID_W ≥ NUM_REQ.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- enable  input  1  allows new arbitration; a locked packet always completes regardless.
- req  input  NUM_REQ  per-requester flit-valid/request.
- tail  input  NUM_REQ  per-requester "current flit is tail". Sampled only for the owner. A single-flit packet has req and tail high together.
- avail  input  1  downstream credit/ready; a flit moves only when high.
- grant  output  NUM_REQ  one-hot owner of the output port; all-zero when unowned.
- grant_id  output  ID_W  binary index of the grant bit; 0 when grant is zero.
- grant_valid  output  1  high when the port is locked to an owner (equals |grant).
- xfer  output  1  combinational: grant_valid & avail & req[owner]. This is the flit-transfer strobe to the crossbar and credit logic.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE; grant=0, grant_id=0, grant_valid=0; rr pointer ptr=0.
  - Applies mid-packet: the lock is dropped with no tail required, and ptr returns to 0.
- State machine has two states, IDLE and LOCKED.
- IDLE:
  - If enable=1 and req≠0, the winner is the first set req bit scanning from index ptr upward, wrapping from NUM_REQ-1 to 0.
  - Next edge: grant=onehot(winner), grant_id=winner, state=LOCKED. Latency from req to grant is 1 cycle.
  - enable=0 or req=0: stay IDLE, outputs 0.
- LOCKED:
  - Owner is fixed; req/tail of other requesters are ignored.
  - On a cycle with xfer=1 and tail[owner]=0: stay LOCKED.
  - On a cycle with xfer=1 and tail[owner]=1: release. At the next edge, grant=0, state=IDLE, ptr=(owner+1) mod NUM_REQ.
  - The release cycle forces one idle bubble. The earliest next grant appears 2 cycles after the tail transfer.
  - If req[owner] drops mid-packet, the lock is held indefinitely with xfer=0 (flit bubble, not abort).
  - avail=0 stalls: xfer=0, lock held, tail not consumed.
  - enable is ignored while LOCKED.
- Fairness:
  - ptr changes only on release.
  - Any continuously requesting input is granted within NUM_REQ packets.
- grant_id is registered together with grant and must always equal encode(grant).
- Invariant: grant is always zero or one-hot.

Test Plan:
- Reset, then req=8'b0000_0100, tail=8'b0000_0100, avail=1 → cycle+1: grant=0x04, grant_id=2, xfer=1. Cycle+2: grant=0, ptr=3.
- req=0xFF held, every flit a tail, avail=1 → grant_id sequence 0,1,2,…,7,0 with one idle cycle between grants. Verifies wrap and rr order.
- 4-flit packet on req[5] (tail on 4th xfer), avail toggled 1,0,1,0,… → grant=0x20 held throughout. Exactly 4 xfer pulses; release only after the 4th. Other req bits asserted meanwhile never granted.
- Locked on req[1], reset asserted after 2 flits → next cycle grant=0, grant_valid=0. After reset with req=0x0A, the winner is 1 (ptr=0).
- enable=0 with req=0x10 → grant stays 0. enable rises → grant=0x10 one cycle later. enable dropped mid-packet → packet still completes through its tail.
- Owner req[3] drops for 3 cycles mid-packet → xfer=0, lock held. Then resumes and finishes with tail; ptr=4 afterwards.

Source files
------------

// File: rtl/noc_output_arbiter.sv
// Round-robin wormhole arbiter for one router output port; grant is registered, one cycle after request.
// The lock is held through avail=0 stalls and owner request bubbles, and is released only when the tail flit transfers.
module noc_output_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] tail,
  input  logic               avail,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_valid,
  output logic               xfer
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [ID_W-1:0]    grant_id_q;
  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    ptr_d;

  logic               win_vld;
  logic [NUM_REQ-1:0] win_oh;
  logic               owner_req;
  logic               owner_tail;

  function automatic logic [ID_W-1:0] onehot_to_bin(input logic [NUM_REQ-1:0] oh);
    logic [ID_W-1:0] bin;
    bin = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) bin = bin | ID_W'(i);
    end
    return bin;
  endfunction

  // The first pass covers indices at or above ptr; the second pass wraps around to the bottom.
  always_comb begin
    win_vld = 1'b0;
    win_oh  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_vld && req[i] && (ID_W'(i) >= ptr_q)) begin
        win_vld   = 1'b1;
        win_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_vld && req[i]) begin
        win_vld   = 1'b1;
        win_oh[i] = 1'b1;
      end
    end
  end

  assign owner_req  = |(req  & grant_q);
  assign owner_tail = |(tail & grant_q);
  assign ptr_d      = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable && win_vld) begin
            grant_q    <= win_oh;
            grant_id_q <= onehot_to_bin(win_oh);
            state_q    <= LOCKED;
          end
        end
        LOCKED: begin
          if (xfer && owner_tail) begin
            grant_q    <= '0;
            grant_id_q <= '0;
            ptr_q      <= ptr_d;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          grant_q    <= '0;
          grant_id_q <= '0;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = (state_q == LOCKED);
  assign xfer        = grant_valid & avail & owner_req;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed bench for noc_output_arbiter: covers round-robin order, packet locking, stalls, enable gating and reset.
module tb_noc_output_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] req;
  logic [7:0] tail;
  logic       avail;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       xfer;

  int checks   = 0;
  int failures = 0;
  int pulses;
  logic seen;

  noc_output_arbiter #(.NUM_REQ(8), .ID_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .req        (req),
    .tail       (tail),
    .avail      (avail),
    .grant      (grant),
    .grant_id   (grant_id),
    .grant_valid(grant_valid),
    .xfer       (xfer)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [7:0] eg, input logic [2:0] eid);
    chk({tag, ".grant"},       32'(grant),       32'(eg));
    chk({tag, ".grant_id"},    32'(grant_id),    32'(eid));
    chk({tag, ".grant_valid"}, 32'(grant_valid), 32'(eg != 8'h00));
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    req    = 8'h00;
    tail   = 8'h00;
    avail  = 1'b1;
    cyc();
    cyc();
    chk_state("reset", 8'h00, 3'd0);
    chk("reset.xfer", 32'(xfer), 32'd0);
    rst_n = 1'b1;

    // Single-flit packet on requester 2, then confirm ptr moved to 3.
    req  = 8'h04;
    tail = 8'h04;
    #1;
    chk("t1.idle_xfer", 32'(xfer), 32'd0);
    cyc();
    chk_state("t1.grant", 8'h04, 3'd2);
    chk("t1.xfer", 32'(xfer), 32'd1);
    req  = 8'h0C;
    tail = 8'h0C;
    cyc();
    chk_state("t1.bubble", 8'h00, 3'd0);
    cyc();
    chk_state("t1.ptr3", 8'h08, 3'd3);
    cyc();
    chk_state("t1.release", 8'h00, 3'd0);
    req  = 8'h00;
    tail = 8'h00;

    // All requesters, single-flit packets: order 0..7,0 with a bubble between grants.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    req   = 8'hFF;
    tail  = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      cyc();
      chk_state($sformatf("t2.grant%0d", k), 8'h01 << (k % 8), 3'(k % 8));
      chk($sformatf("t2.xfer%0d", k), 32'(xfer), 32'd1);
      cyc();
      chk_state($sformatf("t2.bubble%0d", k), 8'h00, 3'd0);
    end
    req  = 8'h00;
    tail = 8'h00;

    // 4-flit packet on requester 5 with avail toggling; other requests and tails must be ignored.
    req = 8'h20;
    cyc();
    chk_state("t3.grant", 8'h20, 3'd5);
    pulses = 0;
    for (int c = 0; c < 7; c++) begin
      avail = (c % 2 == 0);
      req   = 8'hFF;
      tail  = 8'hDF | ((pulses == 3) ? 8'h20 : 8'h00);
      #1;
      seen = xfer;
      chk($sformatf("t3.xfer%0d", c), 32'(seen), 32'(avail));
      if (seen) pulses++;
      cyc();
      if (c < 6) chk_state($sformatf("t3.hold%0d", c), 8'h20, 3'd5);
    end
    chk_state("t3.release", 8'h00, 3'd0);
    chk("t3.pulses", 32'(pulses), 32'd4);
    avail = 1'b1;
    cyc();
    chk_state("t3.next_rr", 8'h40, 3'd6);

    // Reset drops the lock without a tail and returns ptr to 0.
    rst_n = 1'b0;
    cyc();
    chk_state("t4.reset_a", 8'h00, 3'd0);
    rst_n = 1'b1;
    req   = 8'h02;
    tail  = 8'h00;
    cyc();
    chk_state("t4.grant", 8'h02, 3'd1);
    cyc();
    cyc();
    chk_state("t4.two_flits", 8'h02, 3'd1);
    rst_n = 1'b0;
    cyc();
    chk_state("t4.reset_midpkt", 8'h00, 3'd0);
    rst_n = 1'b1;
    req   = 8'h0A;
    cyc();
    chk_state("t4.ptr0_winner", 8'h02, 3'd1);
    tail = 8'h02;
    cyc();
    chk_state("t4.release", 8'h00, 3'd0);
    req  = 8'h00;
    tail = 8'h00;

    // Enable gates new arbitration only; a locked packet still completes.
    enable = 1'b0;
    req    = 8'h10;
    cyc();
    chk_state("t5.disabled_a", 8'h00, 3'd0);
    cyc();
    chk_state("t5.disabled_b", 8'h00, 3'd0);
    enable = 1'b1;
    cyc();
    chk_state("t5.enabled", 8'h10, 3'd4);
    enable = 1'b0;
    cyc();
    chk_state("t5.enable_low_hold", 8'h10, 3'd4);
    tail = 8'h10;
    #1;
    chk("t5.tail_xfer", 32'(xfer), 32'd1);
    cyc();
    chk_state("t5.release", 8'h00, 3'd0);
    cyc();
    chk_state("t5.stay_idle", 8'h00, 3'd0);
    enable = 1'b1;
    req    = 8'h00;
    tail   = 8'h00;

    // Owner request bubble: lock held with no transfers, then the packet finishes and ptr becomes 4.
    req = 8'h08;
    cyc();
    chk_state("t6.grant", 8'h08, 3'd3);
    cyc();
    req = 8'h00;
    #1;
    chk("t6.bubble_xfer", 32'(xfer), 32'd0);
    for (int b = 0; b < 3; b++) begin
      cyc();
      chk_state($sformatf("t6.hold%0d", b), 8'h08, 3'd3);
      chk($sformatf("t6.noxfer%0d", b), 32'(xfer), 32'd0);
    end
    req  = 8'h08;
    tail = 8'h08;
    #1;
    chk("t6.tail_xfer", 32'(xfer), 32'd1);
    cyc();
    chk_state("t6.release", 8'h00, 3'd0);
    req  = 8'h18;
    tail = 8'h18;
    cyc();
    chk_state("t6.ptr4", 8'h10, 3'd4);
    cyc();
    chk_state("t6.final_release", 8'h00, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
